// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with registered read port, occupancy count,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
module fifo_sync_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, overflow_q, underflow_q;
    logic              wr_acc, rd_acc;

    // Flags decode only the registered count, so inputs never glitch them.
    assign full         = count_q == DEPTH_C;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= AF_C;
    assign almost_empty = count_q <= AE_C;
    assign wr_acc       = wr_en & ~full;
    assign rd_acc       = rd_en & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d  = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
        count_d   = (wr_acc && !rd_acc) ? count_q + 1'b1 :
                    (rd_acc && !wr_acc) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_acc;
            overflow_q  <= wr_en & full;
            underflow_q <= rd_en & empty;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of fifo_sync_param in the default 8x16
// configuration and a 32x4 configuration with AF=3, AE=1.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en = 0, rd_en = 0;
    logic [7:0] wr_data = '0, rd_data;
    logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic        b_wr_en = 0, b_rd_en = 0;
    logic [31:0] b_wr_data = '0, b_rd_data;
    logic        b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0]  b_count;

    int checks = 0;
    int failures = 0;

    fifo_sync_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_sync_param #(.DATA_W(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .rd_en(b_rd_en),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick(); rst = 0;
        wr_en = 1; wr_data = 8'hAA; tick();
        wr_data = 8'hBB; tick();
        wr_en = 0; rd_en = 1; tick();
        checks++; if (rd_data !== 8'hAA) begin failures++; $display("FAIL pre_reset_rd_data got=%h exp=aa", rd_data); end
        wr_en = 1; wr_data = 8'hCC; rst = 1; tick(); tick();
        rst = 0; wr_en = 0; rd_en = 0;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost got=%b%b exp=10", almost_empty, almost_full); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd got=%b/%h exp=0/00", rd_valid, rd_data); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", overflow, underflow); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1; wr_data = 8'(i); tick();
            checks++; if (count !== 5'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (almost_full !== (i >= 12)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, i >= 12); end
            checks++; if (full !== (i == 16) || empty !== 1'b0) begin failures++; $display("FAIL fill_full i=%0d got=%b%b exp=%b0", i, full, empty, i == 16); end
        end
        wr_data = 8'h77; tick();
        wr_en = 0;
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL fill_overflow got=%b/%0d exp=1/16", overflow, count); end
        tick();
        checks++; if (overflow !== 1'b0 || count !== 5'd16) begin failures++; $display("FAIL fill_overflow_clear got=%b/%0d exp=0/16", overflow, count); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1; tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin failures++; $display("FAIL drain_data i=%0d got=%b/%h exp=1/%h", i, rd_valid, rd_data, 8'(i)); end
            checks++; if (count !== 5'(16 - i)) begin failures++; $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, 16 - i); end
            checks++; if (almost_empty !== (16 - i <= 4) || empty !== (i == 16)) begin failures++; $display("FAIL drain_flags i=%0d got=%b%b exp=%b%b", i, almost_empty, empty, 16 - i <= 4, i == 16); end
        end
        tick();
        rd_en = 0;
        checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL drain_underflow got=%b/%b exp=1/0", underflow, rd_valid); end
        checks++; if (rd_data !== 8'h10 || count !== 5'd0) begin failures++; $display("FAIL drain_hold got=%h/%0d exp=10/0", rd_data, count); end
        tick();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drain_underflow_clear got=%b exp=0", underflow); end
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 2; r++) begin
            int n;
            n = (r == 0) ? 10 : 12;
            for (int i = 0; i < n; i++) begin
                wr_en = 1; wr_data = 8'(8'h20 + 8'(r * 16) + 8'(i)); tick();
            end
            wr_en = 0;
            checks++; if (count !== 5'(n)) begin failures++; $display("FAIL wrap_count r=%0d got=%0d exp=%0d", r, count, n); end
            for (int i = 0; i < n; i++) begin
                rd_en = 1; tick();
                checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(8'h20 + 8'(r * 16) + 8'(i))) begin failures++; $display("FAIL wrap_data r=%0d i=%0d got=%h exp=%h", r, i, rd_data, 8'h20 + r * 16 + i); end
            end
            rd_en = 0;
            checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty r=%0d got=%b exp=1", r, empty); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = 8'(8'h40 + 8'(i)); tick(); end
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; rd_en = 1; wr_data = 8'(8'h45 + 8'(i)); tick();
            checks++; if (count !== 5'd5 || rd_data !== 8'(8'h40 + 8'(i)) || rd_valid !== 1'b1) begin failures++; $display("FAIL simul_step i=%0d got=%0d/%h exp=5/%h", i, count, rd_data, 8'h40 + i); end
        end
        wr_en = 0;
        for (int i = 0; i < 5; i++) begin
            rd_en = 1; tick();
            checks++; if (rd_data !== 8'(8'h48 + 8'(i))) begin failures++; $display("FAIL simul_drain i=%0d got=%h exp=%h", i, rd_data, 8'h48 + i); end
        end
        rd_en = 0;
        for (int i = 0; i < 16; i++) begin wr_en = 1; wr_data = 8'(8'h60 + 8'(i)); tick(); end
        rd_en = 1; wr_data = 8'hEE; tick();
        wr_en = 0;
        checks++; if (count !== 5'd15 || overflow !== 1'b1) begin failures++; $display("FAIL simul_full got=%0d/%b exp=15/1", count, overflow); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h60) begin failures++; $display("FAIL simul_full_rd got=%b/%h exp=1/60", rd_valid, rd_data); end
        for (int i = 1; i < 16; i++) begin
            tick();
            checks++; if (rd_data !== 8'(8'h60 + 8'(i))) begin failures++; $display("FAIL simul_full_drain i=%0d got=%h exp=%h", i, rd_data, 8'h60 + i); end
        end
        wr_en = 1; wr_data = 8'h99; tick();
        wr_en = 0; rd_en = 0;
        checks++; if (count !== 5'd1 || underflow !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL simul_empty got=%0d/%b/%b exp=1/1/0", count, underflow, rd_valid); end
        rd_en = 1; tick();
        rd_en = 0;
        checks++; if (rd_data !== 8'h99 || count !== 5'd0) begin failures++; $display("FAIL simul_empty_rd got=%h/%0d exp=99/0", rd_data, count); end
    endtask

    task automatic test_params();
        checks++; if (b_count !== 3'd0 || b_empty !== 1'b1 || b_ae !== 1'b1) begin failures++; $display("FAIL p_idle got=%0d/%b/%b exp=0/1/1", b_count, b_empty, b_ae); end
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 4; i++) begin
                b_wr_en = 1; b_wr_data = 32'hA500_0000 + 32'(r * 16 + i); tick();
                checks++; if (b_count !== 3'(i) || b_af !== (i >= 3) || b_ae !== (i <= 1) || b_full !== (i == 4)) begin failures++; $display("FAIL p_fill r=%0d i=%0d got=%0d/%b%b%b", r, i, b_count, b_af, b_ae, b_full); end
            end
            tick();
            b_wr_en = 0;
            checks++; if (b_ovf !== 1'b1 || b_count !== 3'd4) begin failures++; $display("FAIL p_ovf r=%0d got=%b/%0d exp=1/4", r, b_ovf, b_count); end
            for (int i = 1; i <= 4; i++) begin
                b_rd_en = 1; tick();
                checks++; if (b_rd_data !== 32'hA500_0000 + 32'(r * 16 + i) || b_count !== 3'(4 - i)) begin failures++; $display("FAIL p_drain r=%0d i=%0d got=%h/%0d", r, i, b_rd_data, b_count); end
            end
            tick();
            b_rd_en = 0;
            checks++; if (b_unf !== 1'b1 || b_rd_valid !== 1'b0) begin failures++; $display("FAIL p_unf r=%0d got=%b/%b exp=1/0", r, b_unf, b_rd_valid); end
            b_wr_en = 1; b_wr_data = 32'hDEAD_0000 + 32'(r); tick();
            b_wr_en = 0; b_rd_en = 1; tick();
            b_rd_en = 0;
            checks++; if (b_rd_data !== 32'hDEAD_0000 + 32'(r)) begin failures++; $display("FAIL p_shift r=%0d got=%h", r, b_rd_data); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
